add_seq_ctrl: RTL



---
 rtl/add_seq_ctrl_pkg.sv | 15 +
 rtl/add2_slice.sv | 28 ++
 rtl/add_seq_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the sequential slice adder.
package add_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Step counter needs at least one bit even when a single slice pass suffices.
   function automatic int cnt_width(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/add2_slice.sv
// Combinational 2-bit ripple adder built from two gate-level full adders.
// No latency, no handshake.
module add2_slice (
   output logic       co,
   output logic [1:0] s,
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       ci
);

   logic       c1;
   logic [1:0] axb;
   logic [1:0] gen;
   logic [1:0] prop;

   xor u_x0 (axb[0], a[0], b[0]);
   xor u_s0 (s[0], axb[0], ci);
   and u_g0 (gen[0], a[0], b[0]);
   and u_p0 (prop[0], axb[0], ci);
   or  u_c0 (c1, gen[0], prop[0]);

   xor u_x1 (axb[1], a[1], b[1]);
   xor u_s1 (s[1], axb[1], c1);
   and u_g1 (gen[1], a[1], b[1]);
   and u_p1 (prop[1], axb[1], c1);
   or  u_c1 (co, gen[1], prop[1]);

endmodule

// File: rtl/add_seq_ctrl.sv
// WIDTH-bit add computed two bits per cycle through one shared add2_slice; one add in flight.
// Result valid WIDTH/2 cycles after request handshake; held stable in DONE until rsp_ready.
module add_seq_ctrl
   import add_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int STEPS = WIDTH / 2;
   localparam int CW    = cnt_width(STEPS);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             slice_co;
   logic [1:0]       slice_s;
   logic [WIDTH-1:0] sum_shift;

   add2_slice u_slice (
      .co (slice_co),
      .s  (slice_s),
      .a  (a_sh_q[1:0]),
      .b  (b_sh_q[1:0]),
      .ci (carry_q)
   );

   // Each new digit enters at the top so the LS digit lands at bit 0 after the last step.
   generate
      if (WIDTH == 2) begin : g_narrow
         assign sum_shift = slice_s;
      end else begin : g_wide
         assign sum_shift = {slice_s, sum_sh_q[WIDTH-1:2]};
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               a_sh_d   = a;
               b_sh_d   = b;
               carry_d  = cin;
               cnt_d    = '0;
               sum_sh_d = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_d   = a_sh_q >> 2;
            b_sh_d   = b_sh_q >> 2;
            sum_sh_d = sum_shift;
            carry_d  = slice_co;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign sum       = sum_sh_q;
   assign cout      = carry_q;

endmodule
